// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: trap/redirect/RAS-return selection,
// fetch valid/ready handshake and a small circular return-address stack.
module pc_gen #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(32'h0040_0000),
  parameter int unsigned     PC_INC     = 1,
  parameter int unsigned     RAS_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  input  logic            pc_ready,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            ras_empty,
  output logic            ras_full
);

  localparam int unsigned     PTR_W   = $clog2(RAS_DEPTH);
  localparam int unsigned     CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [XLEN-1:0] INC     = XLEN'(PC_INC);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];

  logic             ras_we;
  logic [PTR_W-1:0] ras_waddr;
  logic             pop_ok;

  assign pop_ok    = ras_pop && (count_q != '0);
  assign ras_empty = (count_q == '0);
  assign ras_full  = (count_q == DEPTH_C);
  assign pc_out    = pc_q;
  assign pc_valid  = valid_q;

  always_comb begin
    pc_d      = pc_q;
    valid_d   = valid_q;
    top_d     = top_q;
    count_d   = count_q;
    ras_we    = 1'b0;
    ras_waddr = top_q;

    if (trap_valid) begin
      pc_d    = trap_pc;
      valid_d = 1'b1;
    end else if (redirect_valid) begin
      pc_d    = redirect_pc;
      valid_d = 1'b1;
    end else if (pop_ok) begin
      pc_d    = ras_q[top_q];
      valid_d = 1'b1;
    end else if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      if (!valid_q) begin
        valid_d = 1'b1;
      end else if (pc_ready) begin
        pc_d = pc_q + INC;
      end
    end

    // Stack bookkeeping runs independently of which source won the PC select.
    if (trap_valid) begin
      top_d   = '0;
      count_d = '0;
    end else if (ras_push && pop_ok) begin
      ras_we    = 1'b1;
      ras_waddr = top_q;
    end else if (ras_push) begin
      ras_we    = 1'b1;
      ras_waddr = top_q + PTR_W'(1);
      top_d     = top_q + PTR_W'(1);
      if (count_q != DEPTH_C) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop_ok) begin
      top_d   = top_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_ADDR;
      valid_q <= 1'b0;
      top_q   <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      top_q   <= top_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (ras_we) begin
      ras_q[ras_waddr] <= ras_push_addr;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, randomized run against
// a queue-based reference model, and a second instance with byte increment.
module tb_pc_gen;

  localparam logic [31:0] RST = 32'h0040_0000;

  localparam logic [6:0] C_STALL = 7'h01;
  localparam logic [6:0] C_FLUSH = 7'h02;
  localparam logic [6:0] C_REDIR = 7'h04;
  localparam logic [6:0] C_TRAP  = 7'h08;
  localparam logic [6:0] C_PUSH  = 7'h10;
  localparam logic [6:0] C_POP   = 7'h20;
  localparam logic [6:0] C_RDY   = 7'h40;

  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] redirPc;
    logic [31:0] trapPc;
    logic [31:0] pushAddr;
    logic [31:0] expPc;
    logic        expValid;
    logic        expEmpty;
    logic        expFull;
  } vecT;

  logic        clk;
  logic        reset_n;
  logic        stall, flush, redirect_valid, trap_valid, ras_push, ras_pop, pc_ready;
  logic [31:0] redirect_pc, trap_pc, ras_push_addr;
  logic [31:0] pcOut0, pcOut1;
  logic        pcValid0, pcValid1, rasEmpty0, rasEmpty1, rasFull0, rasFull1;

  int checks = 0;
  int errors = 0;

  logic [31:0] mPc [2];
  logic        mValid [2];
  logic [31:0] mRas [$];
  logic [31:0] mInc [2];

  vecT vecs [$];

  pc_gen u_dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .pc_ready(pc_ready), .pc_out(pcOut0), .pc_valid(pcValid0),
    .ras_empty(rasEmpty0), .ras_full(rasFull0)
  );

  pc_gen #(.PC_INC(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .pc_ready(pc_ready), .pc_out(pcOut1), .pc_valid(pcValid1),
    .ras_empty(rasEmpty1), .ras_full(rasFull1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vecT mk(input logic [6:0] ctl, input logic [31:0] rp, input logic [31:0] tp,
                             input logic [31:0] pa, input logic [31:0] ep, input logic ev,
                             input logic ee, input logic ef);
    vecT v;
    v.ctl = ctl; v.redirPc = rp; v.trapPc = tp; v.pushAddr = pa;
    v.expPc = ep; v.expValid = ev; v.expEmpty = ee; v.expFull = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mPc[k]    = RST;
      mValid[k] = 1'b0;
    end
    mRas.delete();
  endtask

  task automatic modelStep();
    bit popOk;
    popOk = ras_pop && (mRas.size() > 0);
    for (int k = 0; k < 2; k++) begin
      if (trap_valid) begin
        mPc[k] = trap_pc; mValid[k] = 1'b1;
      end else if (redirect_valid) begin
        mPc[k] = redirect_pc; mValid[k] = 1'b1;
      end else if (popOk) begin
        mPc[k] = mRas[$]; mValid[k] = 1'b1;
      end else if (flush) begin
        mValid[k] = 1'b0;
      end else if (stall) begin
        mValid[k] = mValid[k];
      end else if (!mValid[k]) begin
        mValid[k] = 1'b1;
      end else if (pc_ready) begin
        mPc[k] = mPc[k] + mInc[k];
      end
    end
    if (trap_valid) begin
      mRas.delete();
    end else if (ras_push && popOk) begin
      mRas[mRas.size() - 1] = ras_push_addr;
    end else if (ras_push) begin
      mRas.push_back(ras_push_addr);
      if (mRas.size() > 4) void'(mRas.pop_front());
    end else if (popOk) begin
      void'(mRas.pop_back());
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".pc"},     pcOut0, mPc[0]);
    chk({tag, ".valid"},  {31'b0, pcValid0}, {31'b0, mValid[0]});
    chk({tag, ".empty"},  {31'b0, rasEmpty0}, {31'b0, mRas.size() == 0});
    chk({tag, ".full"},   {31'b0, rasFull0}, {31'b0, mRas.size() == 4});
    chk({tag, ".pc4"},    pcOut1, mPc[1]);
    chk({tag, ".valid4"}, {31'b0, pcValid1}, {31'b0, mValid[1]});
    chk({tag, ".empty4"}, {31'b0, rasEmpty1}, {31'b0, mRas.size() == 0});
    chk({tag, ".full4"},  {31'b0, rasFull1}, {31'b0, mRas.size() == 4});
  endtask

  task automatic applyStimulus(input logic [6:0] ctl, input logic [31:0] rp,
                               input logic [31:0] tp, input logic [31:0] pa);
    stall          = ctl[0];
    flush          = ctl[1];
    redirect_valid = ctl[2];
    trap_valid     = ctl[3];
    ras_push       = ctl[4];
    ras_pop        = ctl[5];
    pc_ready       = ctl[6];
    redirect_pc    = rp;
    trap_pc        = tp;
    ras_push_addr  = pa;
  endtask

  task automatic stepCycle(input string tag);
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    mInc[0] = 32'd1;
    mInc[1] = 32'd4;
    reset_n = 1'b0;
    applyStimulus(7'h00, 32'h0, 32'h0, 32'h0);
    modelReset();

    vecs.push_back(mk(C_RDY, 0, 0, 0, 32'h0040_0000, 1, 1, 0));
    vecs.push_back(mk(C_RDY, 0, 0, 0, 32'h0040_0001, 1, 1, 0));
    vecs.push_back(mk(C_RDY, 0, 0, 0, 32'h0040_0002, 1, 1, 0));
    vecs.push_back(mk(7'h00, 0, 0, 0, 32'h0040_0002, 1, 1, 0));
    vecs.push_back(mk(C_RDY | C_STALL, 0, 0, 0, 32'h0040_0002, 1, 1, 0));
    vecs.push_back(mk(C_RDY | C_STALL | C_REDIR, 32'h0, 0, 0, 32'h0000_0000, 1, 1, 0));
    vecs.push_back(mk(C_RDY | C_REDIR, 32'h0040_0010, 0, 0, 32'h0040_0010, 1, 1, 0));
    vecs.push_back(mk(C_RDY | C_FLUSH, 0, 0, 0, 32'h0040_0010, 0, 1, 0));
    vecs.push_back(mk(C_RDY, 0, 0, 0, 32'h0040_0010, 1, 1, 0));
    vecs.push_back(mk(C_RDY, 0, 0, 0, 32'h0040_0011, 1, 1, 0));
    vecs.push_back(mk(C_RDY | C_PUSH, 0, 0, 32'hA, 32'h0040_0012, 1, 0, 0));
    vecs.push_back(mk(C_RDY | C_PUSH, 0, 0, 32'hB, 32'h0040_0013, 1, 0, 0));
    vecs.push_back(mk(C_RDY | C_PUSH, 0, 0, 32'hC, 32'h0040_0014, 1, 0, 0));
    vecs.push_back(mk(C_RDY | C_PUSH, 0, 0, 32'hD, 32'h0040_0015, 1, 0, 1));
    vecs.push_back(mk(C_RDY | C_PUSH, 0, 0, 32'hE, 32'h0040_0016, 1, 0, 1));
    vecs.push_back(mk(C_RDY | C_POP, 0, 0, 0, 32'hE, 1, 0, 0));
    vecs.push_back(mk(C_RDY | C_POP, 0, 0, 0, 32'hD, 1, 0, 0));
    vecs.push_back(mk(C_RDY | C_POP, 0, 0, 0, 32'hC, 1, 0, 0));
    vecs.push_back(mk(C_RDY | C_POP, 0, 0, 0, 32'hB, 1, 1, 0));
    vecs.push_back(mk(C_RDY | C_POP, 0, 0, 0, 32'hC, 1, 1, 0));
    vecs.push_back(mk(C_RDY | C_PUSH | C_POP, 0, 0, 32'h50, 32'hD, 1, 0, 0));
    vecs.push_back(mk(C_RDY | C_PUSH | C_POP, 0, 0, 32'h60, 32'h50, 1, 0, 0));
    vecs.push_back(mk(C_RDY | C_POP, 0, 0, 0, 32'h60, 1, 1, 0));
    vecs.push_back(mk(C_RDY | C_PUSH, 0, 0, 32'h70, 32'h61, 1, 0, 0));
    vecs.push_back(mk(C_RDY | C_REDIR | C_POP, 32'h300, 0, 0, 32'h300, 1, 1, 0));
    vecs.push_back(mk(C_RDY | C_PUSH, 0, 0, 32'h80, 32'h301, 1, 0, 0));
    vecs.push_back(mk(C_RDY | C_TRAP | C_REDIR | C_PUSH, 32'h200, 32'h100, 32'h90, 32'h100, 1, 1, 0));
    vecs.push_back(mk(C_RDY | C_REDIR, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 1, 1, 0));
    vecs.push_back(mk(C_RDY, 0, 0, 0, 32'h0000_0000, 1, 1, 0));
    vecs.push_back(mk(C_RDY | C_FLUSH | C_STALL, 0, 0, 0, 32'h0000_0000, 0, 1, 0));
    vecs.push_back(mk(C_RDY | C_STALL, 0, 0, 0, 32'h0000_0000, 0, 1, 0));
    vecs.push_back(mk(C_RDY, 0, 0, 0, 32'h0000_0000, 1, 1, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset.pc", pcOut0, RST);
    chk("reset.valid", {31'b0, pcValid0}, 32'h0);
    chk("reset.empty", {31'b0, rasEmpty0}, 32'h1);
    checkOutput("reset");
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ctl, vecs[i].redirPc, vecs[i].trapPc, vecs[i].pushAddr);
      stepCycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tpc", i), pcOut0, vecs[i].expPc);
      chk($sformatf("vec%0d.tvalid", i), {31'b0, pcValid0}, {31'b0, vecs[i].expValid});
      chk($sformatf("vec%0d.tempty", i), {31'b0, rasEmpty0}, {31'b0, vecs[i].expEmpty});
      chk($sformatf("vec%0d.tfull", i), {31'b0, rasFull0}, {31'b0, vecs[i].expFull});
    end

    // Asynchronous reset in the middle of a cycle must act without a clock edge.
    reset_n = 1'b0;
    #1;
    chk("midrst.pc", pcOut0, RST);
    chk("midrst.valid", {31'b0, pcValid0}, 32'h0);
    chk("midrst.pc4", pcOut1, RST);
    modelReset();
    checkOutput("midrst");
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 800; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      applyStimulus({ $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) == 0,
                      $urandom_range(0, 3) == 0,
                      $urandom_range(0, 15) == 0,
                      $urandom_range(0, 7) == 0,
                      $urandom_range(0, 7) == 0,
                      $urandom_range(0, 5) == 0 },
                    rp, $urandom, $urandom);
      stepCycle($sformatf("rand%0d", i));
    end

    // Byte-addressed instance steps by four from the reset vector.
    reset_n = 1'b0;
    applyStimulus(C_RDY, 0, 0, 0);
    modelReset();
    #1;
    reset_n = 1'b1;
    stepCycle("inc4a");
    chk("inc4a.pc4", pcOut1, 32'h0040_0000);
    stepCycle("inc4b");
    chk("inc4b.pc4", pcOut1, 32'h0040_0004);
    chk("inc4b.pc", pcOut0, 32'h0040_0001);
    stepCycle("inc4c");
    chk("inc4c.pc4", pcOut1, 32'h0040_0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
